// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Interface   : uart_tx_scheduler_if
//  Description : Requester-side byte-stream bus of the UART TX scheduler.
//                One valid/data/last lane per requester plus a per-requester
//                ready returned by the scheduler. A byte moves when valid and
//                ready are both high on the same rising clock edge.
//  Signals     : req_valid [NUM_REQ]              byte valid, per requester
//                req_data  [NUM_REQ*FRAME_WIDTH]  lane i at [i*FRAME_WIDTH +: FRAME_WIDTH]
//                req_last  [NUM_REQ]              byte closes its packet
//                req_ready [NUM_REQ]              one-hot accept pulse
//  Modports    : master - requester side (drives valid/data/last)
//                slave  - scheduler side (drives ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_WIDTH = 8
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*FRAME_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART transmitter among NUM_REQ byte-stream
//                requesters. Round-robin arbitration; a grant is kept for a
//                whole packet (through req_last) or until MAX_BURST frames
//                have been sent, whichever comes first. A granted requester
//                that goes quiet mid-packet is released after HOLD_TIMEOUT
//                clocks. The transmitter is driven through tx_din/tx_start and
//                completion is tracked with tx_ready/tx_done_tick.
//  Parameters  : NUM_REQ       number of requesters (2..8)
//                FRAME_WIDTH   data bits per frame (equal to transmitter's)
//                MAX_BURST     frames per grant before forced re-arbitration
//                HOLD_TIMEOUT  clocks a mid-packet grant waits for valid
//  Ports       : clk           system clock, rising edge
//                reset_n       asynchronous active-low reset
//                req           requester bus (slave modport)
//                tx_din        registered frame, stable from LOAD to done
//                tx_start      start request to the transmitter
//                tx_ready      transmitter idle
//                tx_done_tick  transmitter frame-complete pulse
//                grant_id      current / last granted requester
//                busy          high whenever a grant is active
//                frame_done    registered pulse one clock after tx_done_tick
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_WIDTH  = 8,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 1024,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    uart_tx_scheduler_if.slave          req,
    output logic [FRAME_WIDTH-1:0]      tx_din,
    output logic                        tx_start,
    input  wire logic                   tx_ready,
    input  wire logic                   tx_done_tick,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int HOLD_W  = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_NEXT      = 3'd4;
    localparam logic [2:0] ST_HOLD      = 3'd5;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;

    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [BURST_W-1:0]     r_burst_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   r_last;
    logic [FRAME_WIDTH-1:0] r_tx_din;
    logic                   r_frame_done;

    logic                   w_any;
    logic [IDX_W-1:0]       w_pick;
    logic [IDX_W-1:0]       w_cand;
    logic                   w_g_valid;
    logic                   w_g_last;
    logic [FRAME_WIDTH-1:0] w_g_data;
    logic                   w_burst_full;
    logic                   w_hold_expired;
    logic                   w_release;
    logic [NUM_REQ-1:0]     w_req_ready;

    // ------------------------------------------------------------------
    // Round-robin search: first valid index after the last released
    // grant, wrapping modulo NUM_REQ. The pointer itself is checked last,
    // so a requester that just finished yields to everyone else.
    // ------------------------------------------------------------------
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr_ptr;
        w_cand = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_any && req.req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane of the currently granted requester.
    // ------------------------------------------------------------------
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_g_valid = req.req_valid[i];
                w_g_last  = req.req_last[i];
                w_g_data  = req.req_data[i*FRAME_WIDTH +: FRAME_WIDTH];
            end
        end
    end

    // Release happens either at the end of a packet/burst or when a
    // mid-packet grant has idled for the full hold window.
    always_comb begin
        w_burst_full   = (r_burst_cnt == BURST_W'(MAX_BURST));
        w_hold_expired = (r_hold_cnt == HOLD_W'(HOLD_TIMEOUT - 1));
        w_release      = ((r_state == ST_NEXT) && (r_last || w_burst_full)) ||
                         ((r_state == ST_HOLD) && !w_g_valid && w_hold_expired);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = w_g_valid ? ST_START : ST_HOLD;
            end
            ST_START: begin
                // Hold the start request until the transmitter shows it
                // has taken the frame by dropping tx_ready.
                if (!tx_ready) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done_tick) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_state_nxt = w_release ? ST_IDLE : ST_LOAD;
            end
            ST_HOLD: begin
                // A returning valid wins over an expiring hold window.
                if (w_g_valid) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_hold_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the state register
    // ------------------------------------------------------------------
    always_comb begin
        w_req_ready = '0;
        tx_start    = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD: begin
                if (w_g_valid) begin
                    w_req_ready[r_grant] = 1'b1;
                end
            end
            ST_START: begin
                tx_start = 1'b1;
            end
            default: begin
                tx_start = 1'b0;
            end
        endcase
    end

    assign req.req_ready = w_req_ready;

    // ------------------------------------------------------------------
    // Grant, round-robin pointer and per-grant counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant     <= '0;
            r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any) begin
                r_grant     <= w_pick;
                r_burst_cnt <= '0;
            end else if ((r_state == ST_WAIT_DONE) && tx_done_tick && !w_burst_full) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            if (w_release) begin
                r_rr_ptr <= r_grant;
            end
        end
    end

    // Hold window counter: runs only while parked in HOLD, cleared on exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
        end else if ((r_state == ST_HOLD) && !w_g_valid && !w_hold_expired) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end else begin
            r_hold_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Frame data capture and completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_din     <= '0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if ((r_state == ST_LOAD) && w_g_valid) begin
                r_tx_din <= w_g_data;
                r_last   <= w_g_last;
            end
            // Ticks outside WAIT_DONE belong to nobody and are dropped.
            r_frame_done <= (r_state == ST_WAIT_DONE) && tx_done_tick;
        end
    end

    assign tx_din     = r_tx_din;
    assign grant_id   = r_grant;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench for uart_tx_scheduler. Requesters are
//                byte queues, the transmitter is a small timing model, and the
//                expected frame order comes from a packet-level round-robin
//                model evaluated when each batch of requests is loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int FW = 8;
    localparam int MB = 4;
    localparam int HT = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [FW-1:0] tx_din;
    logic          tx_start;
    logic          tx_ready;
    logic          tx_done_tick;
    logic [1:0]    grant_id;
    logic          busy;
    logic          frame_done;

    uart_tx_scheduler_if #(.NUM_REQ(N), .FRAME_WIDTH(FW)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ      (N),
        .FRAME_WIDTH  (FW),
        .MAX_BURST    (MB),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (bus),
        .tx_din       (tx_din),
        .tx_start     (tx_start),
        .tx_ready     (tx_ready),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Requester byte queues: bit 8 = last, bits 7:0 = data.
    bit [8:0]  rq [N][$];
    int        exp_req[$];
    bit [7:0]  exp_dat[$];
    int        mrr;

    int        checks;
    int        failures;
    int        cyc;
    int        tx_cnt;
    logic      prev_done;
    logic [7:0] cur_din;
    logic      s_busy;

    int n_exp, n_start, n_fd, n_acc;
    int t_load, t_ready_first, t_start_first, t_done, min_gap, t_fd, t_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet-level round robin: each grant goes to the first non-empty
    // queue after the previous holder and takes bytes until a last byte,
    // MAX_BURST bytes, or the queue runs dry (hold timeout release).
    function automatic void model_predict();
        bit [8:0] mq [N][$];
        bit [8:0] e;
        int       pick;
        int       n;
        bit       more;
        bit       stop;
        for (int i = 0; i < N; i++) mq[i] = rq[i];
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && mq[(mrr + k) % N].size() > 0) pick = (mrr + k) % N;
            end
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                n    = 0;
                stop = 1'b0;
                while (!stop) begin
                    e = mq[pick].pop_front();
                    exp_req.push_back(pick);
                    exp_dat.push_back(e[7:0]);
                    n++;
                    if (e[8] || n >= MB || mq[pick].size() == 0) stop = 1'b1;
                end
                mrr = pick;
            end
        end
    endfunction

    task automatic drive_reqs();
        bit [8:0] e;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                e = rq[i][0];
                bus.req_valid[i]          = 1'b1;
                bus.req_data[i*FW +: FW]  = e[7:0];
                bus.req_last[i]           = e[8];
            end else begin
                bus.req_valid[i]          = 1'b0;
                bus.req_data[i*FW +: FW]  = '0;
                bus.req_last[i]           = 1'b0;
            end
        end
    endtask

    // One clock: sample and check at the falling edge, then update the
    // requester queues and the transmitter model just after the rising edge.
    task automatic step();
        logic [N-1:0] s_ready;
        logic         s_start;
        @(negedge clk);
        s_ready = bus.req_ready;
        s_start = tx_start;
        s_busy  = busy;
        check("ready_onehot0", 32'($onehot0(s_ready)), 32'd1);
        check("ready_without_valid", 32'(s_ready & ~bus.req_valid), 32'd0);
        check("frame_done_after_tick", 32'(frame_done), 32'(prev_done));
        if (s_ready != '0) begin
            n_acc++;
            if (t_ready_first < 0) t_ready_first = cyc;
        end
        if (s_start && tx_ready) begin
            n_start++;
            if (t_start_first < 0) t_start_first = cyc;
            if (t_done >= 0 && (cyc - t_done) < min_gap) min_gap = cyc - t_done;
            if (exp_req.size() > 0) begin
                check("grant_id", 32'(grant_id), 32'(exp_req[0]));
                check("tx_din", 32'(tx_din), 32'(exp_dat[0]));
                void'(exp_req.pop_front());
                void'(exp_dat.pop_front());
            end else begin
                check("extra_frame", 32'(n_start), 32'(n_exp));
            end
            cur_din = tx_din;
        end
        if (tx_done_tick) begin
            check("tx_din_stable", 32'(tx_din), 32'(cur_din));
            t_done = cyc;
        end
        if (frame_done) begin
            n_fd++;
            if (t_fd < 0) t_fd = cyc;
        end
        if (!s_busy && t_fd >= 0 && t_idle < 0) t_idle = cyc;
        prev_done = tx_done_tick;

        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        if (tx_done_tick) tx_done_tick = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done_tick = 1'b1;
                tx_ready     = 1'b1;
            end
        end else if (s_start && tx_ready) begin
            tx_ready = 1'b0;
            tx_cnt   = int'($urandom_range(5, 2));
        end
        drive_reqs();
    endtask

    task automatic phase_begin();
        exp_req.delete();
        exp_dat.delete();
        model_predict();
        n_exp = exp_req.size();
        n_start = 0; n_fd = 0; n_acc = 0;
        t_load = cyc; t_ready_first = -1; t_start_first = -1;
        t_done = -1; min_gap = 1000; t_fd = -1; t_idle = -1;
        drive_reqs();
    endtask

    function automatic bit all_empty();
        bit r;
        r = 1'b1;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic run_phase(input string name, input int budget);
        int k;
        bit fin;
        phase_begin();
        k   = 0;
        fin = 1'b0;
        while (!fin && k < budget) begin
            step();
            k++;
            fin = all_empty() && exp_req.size() == 0 && !s_busy && tx_ready &&
                  !tx_done_tick && tx_cnt == 0;
        end
        check({name, "_completed"}, 32'(fin), 32'd1);
        check({name, "_frames"}, 32'(n_start), 32'(n_exp));
        check({name, "_frame_done_count"}, 32'(n_fd), 32'(n_exp));
        check({name, "_accepts"}, 32'(n_acc), 32'(n_exp));
        if (!fin) begin
            for (int i = 0; i < N; i++) rq[i].delete();
            drive_reqs();
        end
    endtask

    initial begin
        int  np, len;
        bit  any;
        bit  found;
        checks = 0; failures = 0; cyc = 0;
        tx_ready = 1'b1; tx_done_tick = 1'b0; tx_cnt = 0;
        prev_done = 1'b0; cur_din = '0; s_busy = 1'b0;
        mrr = N - 1;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        reset_n = 1'b0;

        // T0: reset values
        repeat (3) @(posedge clk);
        #1;
        check("T0_tx_start", 32'(tx_start), 32'd0);
        check("T0_tx_din", 32'(tx_din), 32'd0);
        check("T0_req_ready", 32'(bus.req_ready), 32'd0);
        check("T0_grant_id", 32'(grant_id), 32'd0);
        check("T0_busy", 32'(busy), 32'd0);
        check("T0_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: single byte, latency to ready and start
        rq[0].push_back({1'b1, 8'hA5});
        run_phase("T1", 200);
        check("T1_ready_latency", 32'(t_ready_first - t_load), 32'd1);
        check("T1_start_latency", 32'(t_start_first - t_load), 32'd2);
        check("T1_busy_end", 32'(busy), 32'd0);

        // Stray done tick while idle must not produce frame_done
        tx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        tx_done_tick = 1'b0;
        @(negedge clk);
        check("stray_tick_frame_done", 32'(frame_done), 32'd0);
        check("stray_tick_busy", 32'(busy), 32'd0);

        // T2: simultaneous one-byte packets, then 0 and 1 again
        for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
        run_phase("T2a", 400);
        rq[0].push_back({1'b1, 8'h50});
        rq[1].push_back({1'b1, 8'h51});
        run_phase("T2b", 300);

        // T3: packet lock, back-to-back frames within the packet
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        rq[2].push_back({1'b1, 8'h44});
        run_phase("T3", 400);
        check("T3_min_done_to_start", 32'(min_gap), 32'd3);

        // T4: burst cap with a competing requester
        for (int b = 0; b < 9; b++) rq[0].push_back({b == 8, 8'(8'hC0 + b)});
        rq[1].push_back({1'b1, 8'h77});
        run_phase("T4", 800);

        // T5: req3 goes quiet mid-packet; released after the hold window
        rq[3].push_back({1'b0, 8'h3C});
        rq[0].push_back({1'b1, 8'h0F});
        run_phase("T5", 400);
        check("T5_done_to_release", 32'(t_idle - t_fd), 32'd10);

        // T6: reset while waiting for the transmitter
        rq[1].push_back({1'b1, 8'($urandom_range(255, 0))});
        phase_begin();
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            if (busy === 1'b1 && tx_start === 1'b0 && tx_ready === 1'b0 && tx_done_tick === 1'b0)
                found = 1'b1;
        end
        check("T6_reached_wait_done", 32'(found), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("T6_tx_start", 32'(tx_start), 32'd0);
        check("T6_tx_din", 32'(tx_din), 32'd0);
        check("T6_req_ready", 32'(bus.req_ready), 32'd0);
        check("T6_grant_id", 32'(grant_id), 32'd0);
        check("T6_busy", 32'(busy), 32'd0);
        check("T6_frame_done", 32'(frame_done), 32'd0);
        for (int i = 0; i < N; i++) rq[i].delete();
        drive_reqs();
        tx_ready = 1'b1; tx_done_tick = 1'b0; tx_cnt = 0; prev_done = 1'b0;
        mrr = N - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rq[2].push_back({1'b1, 8'h62});
        rq[0].push_back({1'b1, 8'h60});
        run_phase("T6", 300);

        // Randomized batches of packets
        for (int r = 0; r < 6; r++) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1, 0) == 1) begin
                    any = 1'b1;
                    np  = int'($urandom_range(2, 1));
                    for (int p = 0; p < np; p++) begin
                        len = int'($urandom_range(6, 1));
                        for (int b = 0; b < len; b++)
                            rq[i].push_back({b == len - 1, 8'($urandom_range(255, 0))});
                    end
                end
            end
            if (!any) rq[r % N].push_back({1'b1, 8'($urandom_range(255, 0))});
            run_phase("RND", 3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
